// File: rtl/holy_core_pkg.sv
// Shared definitions for the holy core peripherals: AXI-Lite slave states,
// response codes and the interrupt gateway register map.
package holy_core_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LITE_SENDING_READ_DATA,
    LITE_RECEIVING_WRITE_DATA,
    LITE_SENDING_WRITE_RES
  } axi_state_slave_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] GW_TRIGGER = 32'h0;
  localparam logic [31:0] GW_PENDING = 32'h4;
  localparam logic [31:0] GW_RAW     = 32'h8;

  function automatic logic gw_addr_hit(input logic [31:0] addr);
    return (addr == GW_TRIGGER) || (addr == GW_PENDING) || (addr == GW_RAW);
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// Minimal 32-bit AXI-Lite bundle; the slave modport is the register-target view.
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/holy_irq_sync.sv
// Two-flop synchroniser for asynchronous inputs, cleared by a synchronous active-low reset.
module holy_irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/holy_irq_gateway.sv
// Interrupt gateway ahead of holy_plic: synchronises irq lines, applies per-source
// level/edge mode and exposes TRIGGER/PENDING/RAW over AXI-Lite.
module holy_irq_gateway
  import holy_core_pkg::*;
#(
  parameter int NUM_IRQS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQS-1:0] irq_in,
  axi_lite_if.slave           s_axi_lite,
  output logic [NUM_IRQS-1:0] irq_o
);

  logic [NUM_IRQS-1:0] sync_q;
  logic [NUM_IRQS-1:0] prev_q;
  logic [NUM_IRQS-1:0] trigger_q;
  logic [NUM_IRQS-1:0] pending_q;
  logic [NUM_IRQS-1:0] rise;
  logic [NUM_IRQS-1:0] w1c_mask;
  logic [NUM_IRQS-1:0] trigger_next;
  logic [NUM_IRQS-1:0] pending_next;

  axi_state_slave_t state;
  logic [31:0]      addr_q;
  logic [31:0]      rdata_q;
  logic [1:0]       rresp_q;
  logic [1:0]       bresp_q;
  logic [31:0]      rd_word;
  logic [1:0]       rd_resp;
  logic             wr_fire;
  logic             unused_axi;

  holy_irq_sync #(.WIDTH(NUM_IRQS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_in),
    .q     (sync_q)
  );

  assign rise    = sync_q & ~prev_q;
  assign wr_fire = (state == LITE_RECEIVING_WRITE_DATA) && s_axi_lite.wvalid;
  assign irq_o   = (trigger_q & pending_q) | (~trigger_q & sync_q);

  // Masking with the new trigger keeps pending clear for every level-mode source.
  always_comb begin
    w1c_mask     = '0;
    trigger_next = trigger_q;
    if (wr_fire && (addr_q == GW_PENDING)) w1c_mask = s_axi_lite.wdata[NUM_IRQS-1:0];
    if (wr_fire && (addr_q == GW_TRIGGER)) trigger_next = s_axi_lite.wdata[NUM_IRQS-1:0];
    pending_next = ((pending_q & ~w1c_mask) | (rise & trigger_q)) & trigger_next;
  end

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (s_axi_lite.araddr)
      GW_TRIGGER: rd_word[NUM_IRQS-1:0] = trigger_q;
      GW_PENDING: rd_word[NUM_IRQS-1:0] = pending_q;
      GW_RAW:     rd_word[NUM_IRQS-1:0] = sync_q;
      default: begin
        rd_word = 32'hFFFF_FFFF;
        rd_resp = RESP_SLVERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q    <= '0;
      trigger_q <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= sync_q;
      trigger_q <= trigger_next;
      pending_q <= pending_next;
    end
  end

  // Read data is captured at address acceptance so it holds still under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi_lite.arvalid) begin
            addr_q  <= s_axi_lite.araddr;
            rdata_q <= rd_word;
            rresp_q <= rd_resp;
            state   <= LITE_SENDING_READ_DATA;
          end else if (s_axi_lite.awvalid) begin
            addr_q <= s_axi_lite.awaddr;
            state  <= LITE_RECEIVING_WRITE_DATA;
          end
        end
        LITE_SENDING_READ_DATA: begin
          if (s_axi_lite.rready) state <= IDLE;
        end
        LITE_RECEIVING_WRITE_DATA: begin
          if (s_axi_lite.wvalid) begin
            bresp_q <= gw_addr_hit(addr_q) ? RESP_OKAY : RESP_SLVERR;
            state   <= LITE_SENDING_WRITE_RES;
          end
        end
        LITE_SENDING_WRITE_RES: begin
          if (s_axi_lite.bready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_axi_lite.arready = rst_n && (state == IDLE);
  assign s_axi_lite.awready = rst_n && (state == IDLE) && !s_axi_lite.arvalid;
  assign s_axi_lite.rvalid  = rst_n && (state == LITE_SENDING_READ_DATA);
  assign s_axi_lite.rdata   = s_axi_lite.rvalid ? rdata_q : '0;
  assign s_axi_lite.rresp   = s_axi_lite.rvalid ? rresp_q : RESP_OKAY;
  assign s_axi_lite.wready  = rst_n && (state == LITE_RECEIVING_WRITE_DATA);
  assign s_axi_lite.bvalid  = rst_n && (state == LITE_SENDING_WRITE_RES);
  assign s_axi_lite.bresp   = s_axi_lite.bvalid ? bresp_q : RESP_OKAY;

  assign unused_axi = ^{s_axi_lite.wstrb, s_axi_lite.wdata};

endmodule
